pcpu_l1_cache: RTL

// - Direct-mapped, write-through, no-write-allocate L1 cache between the pCPU multicycle core's memory port and the system bus.
// - One 32-bit word per line. Upstream and downstream use the same request/ready protocol as the core.
// - Data is stored in bus byte order; no swapping is done here.
// - Read hits complete in the request cycle. Misses, writes and uncached accesses go to the bus.

---
 rtl/pcpu_l1_cache.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pcpu_l1_cache.sv
// pcpu_l1_cache: direct-mapped, write-through, no-write-allocate L1 between the pCPU core port and the system bus.
// Latency: read hit completes in the request cycle; read miss and write take 2 + bus wait cycles.
// Backpressure: cpu_ready drops from the request cycle until the bus transfer completes; one bus request at a time.
// Optional feature macro: PCPU_CACHE_FLUSH_EN adds a flush input that invalidates every line, one per cycle.
module pcpu_l1_cache #(
    parameter int         INDEX_BITS   = 8,
    parameter logic [3:0] UNCACHED_NIB = 4'hE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_a,
    input  logic [31:0] cpu_d,
    input  logic        cpu_we,
    input  logic        cpu_rd,
`ifdef PCPU_CACHE_FLUSH_EN
    input  logic        flush,
`endif
    output logic [31:0] cpu_spo,
    output logic        cpu_ready,
    output logic [31:0] bus_a,
    output logic [31:0] bus_d,
    output logic        bus_we,
    output logic        bus_rd,
    input  logic [31:0] bus_spo,
    input  logic        bus_ready
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4
`ifdef PCPU_CACHE_FLUSH_EN
        , S_FLUSH = 3'd5
`endif
    } state_t;

    state_t              r_state;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES];
    logic [31:0]         r_rdata;
    logic [31:0]         r_bus_a;
    logic [31:0]         r_bus_d;
    logic                r_bus_rd;
    logic                r_bus_we;
`ifdef PCPU_CACHE_FLUSH_EN
    logic [INDEX_BITS-1:0] r_flush_idx;
`endif

    logic [INDEX_BITS-1:0] w_idx;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [31:0]           w_line;
    logic                  w_cached;
    logic                  w_hit;
    logic                  w_fill_cached;
    logic                  w_rd_done;
    logic                  w_fill;
    logic                  w_wr_hit;

    // Lookup is on the live request address; fill uses the address latched for the bus
    assign w_idx         = cpu_a[INDEX_BITS+1:2];
    assign w_tag         = cpu_a[31:INDEX_BITS+2];
    assign w_cached      = (cpu_a[31:28] != UNCACHED_NIB);
    assign w_line        = r_data[w_idx];
    assign w_hit         = w_cached && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill_idx    = r_bus_a[INDEX_BITS+1:2];
    assign w_fill_cached = (r_bus_a[31:28] != UNCACHED_NIB);
    assign w_rd_done     = ((r_state == S_RD_REQ) || (r_state == S_RD_WAIT)) && bus_ready;
    assign w_fill        = w_rd_done && w_fill_cached;
    assign w_wr_hit      = (r_state == S_IDLE) && cpu_we && w_hit;

    assign bus_a  = r_bus_a;
    assign bus_d  = r_bus_d;
    assign bus_rd = r_bus_rd;
    assign bus_we = r_bus_we;

    // Read hits answer in the request cycle; any other request drops ready at once
    always_comb begin
        cpu_ready = 1'b0;
        cpu_spo   = r_rdata;
        if (r_state == S_IDLE) begin
            if (cpu_we) begin
                cpu_ready = 1'b0;
            end else if (cpu_rd) begin
                cpu_ready = w_hit;
                if (w_hit) begin
                    cpu_spo = w_line;
                end
            end else begin
                cpu_ready = 1'b1;
            end
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone decide whether a line is usable
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_fill_idx] <= bus_spo;
            r_tag[w_fill_idx]  <= r_bus_a[31:INDEX_BITS+2];
        end else if (w_wr_hit) begin
            r_data[w_idx] <= cpu_d;
        end
    end

    // Control FSM: request latching, bus pulses, fill/valid bookkeeping, read-data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_valid  <= '0;
            r_rdata  <= '0;
            r_bus_a  <= '0;
            r_bus_d  <= '0;
            r_bus_rd <= 1'b0;
            r_bus_we <= 1'b0;
`ifdef PCPU_CACHE_FLUSH_EN
            r_flush_idx <= '0;
`endif
        end else begin
            r_bus_rd <= 1'b0;
            r_bus_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_we) begin
                        r_bus_a  <= cpu_a;
                        r_bus_d  <= cpu_d;
                        r_bus_we <= 1'b1;
                        r_state  <= S_WR_REQ;
                    end else if (cpu_rd) begin
                        if (w_hit) begin
                            r_rdata <= w_line;
                        end else begin
                            r_bus_a  <= cpu_a;
                            r_bus_rd <= 1'b1;
                            r_state  <= S_RD_REQ;
                        end
`ifdef PCPU_CACHE_FLUSH_EN
                    end else if (flush) begin
                        r_flush_idx <= '0;
                        r_state     <= S_FLUSH;
`endif
                    end
                end
                S_RD_REQ, S_RD_WAIT: begin
                    if (bus_ready) begin
                        r_rdata <= bus_spo;
                        if (w_fill_cached) begin
                            r_valid[w_fill_idx] <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_RD_WAIT;
                    end
                end
                S_WR_REQ, S_WR_WAIT: begin
                    if (bus_ready) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WR_WAIT;
                    end
                end
`ifdef PCPU_CACHE_FLUSH_EN
                S_FLUSH: begin
                    r_valid[r_flush_idx] <= 1'b0;
                    r_flush_idx          <= r_flush_idx + INDEX_BITS'(1);
                    if (r_flush_idx == '1) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
